song_recorder: RTL and testbench
================================

SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 SHALL have parameter MAX_DUR, default 63, giving the largest duration in beats that one entry can hold.
REQ-002 SHALL have port clk, input, 1 bit, the system clock.
REQ-003 SHALL have port reset, input, 1 bit, a synchronous active-low reset that is asserted when 0.
REQ-004 SHALL have port record_button, input, 1 bit, a debounced one-pulse that starts or stops recording.
REQ-005 SHALL have port song, input, 2 bits, the target song slot, sampled at record start.
REQ-006 SHALL have port beat, input, 1 bit, the 1/48 s beat pulse.
REQ-007 SHALL have port key_press, input, 1 bit, a one-cycle pulse: a key went down.
REQ-008 SHALL have port key_note, input, 6 bits, the note of the pressed key, valid with key_press; 0 is illegal.
REQ-009 SHALL have port key_release, input, 1 bit, a one-cycle pulse: the held key went up.
REQ-010 SHALL have port wr_en, output, 1 bit, the song-memory write strobe.
REQ-011 SHALL have port wr_addr, output, 7 bits, the write address {song, index[4:0]}.
REQ-012 SHALL have port wr_data, output, 16 bits, the entry word {advance, 3'b000, note[5:0], duration[5:0]}, laid out exactly as song_reader consumes it.
REQ-013 SHALL have port recording, output, 1 bit, high while not in IDLE.
REQ-014 SHALL have port full, output, 1 bit, high once index 31 has been reached.
REQ-015 SHALL have port entry_count, output, 6 bits, the number of entries written in the current take, terminator included.

Function
REQ-016 SHALL implement states IDLE, GAP, HOLD, WR_REST, WR_NOTE, WR_END.
REQ-017 SHALL, in IDLE, on record_button: latch song, clear index, dur and entry_count, clear a first_key flag, and go to GAP.
REQ-018 SHALL, in GAP, add 1 to dur on each beat, saturating at MAX_DUR.
REQ-019 SHALL, in GAP, on key_press: latch key_note; go to WR_REST if first_key is set and dur>0, otherwise clear dur, set first_key and go to HOLD.
REQ-020 SHALL drop any leading silence before the first key, so no rest entry is written for it.
REQ-021 SHALL, in WR_REST, write {1, 0, dur} for one cycle, increment index, clear dur and go to HOLD.
REQ-022 SHALL, in HOLD, add 1 to dur on each beat.
REQ-023 SHALL, in HOLD, go to WR_NOTE on key_release.
REQ-024 SHALL, in HOLD, go to WR_NOTE with a continue flag set when dur reaches MAX_DUR.
REQ-025 SHALL, in WR_NOTE, write {1, note, dur} and increment index.
REQ-026 SHALL, after WR_NOTE, clear dur and return to HOLD (same note) if continue is set, otherwise go to GAP.
REQ-027 SHALL, on record_button in GAP or HOLD, flush any pending note (HOLD with dur>0) through WR_NOTE, then go to WR_END.
REQ-028 SHALL discard a pending rest rather than write it when recording stops.
REQ-029 SHALL, in WR_END, write the terminator {0, 0, 0} at the current index and go to IDLE.
REQ-030 SHALL reserve index 31 for the terminator: when a write leaves index at 31, assert full and go directly to WR_END.
REQ-031 SHALL ignore key and button inputs while in any write state.
REQ-032 SHALL apply a beat that coincides with key_press or key_release to the current dur before the transition is taken.
REQ-033 SHALL give key_release priority when key_press and key_release coincide in HOLD; the press is ignored.
REQ-034 SHALL give record_button priority over key events in the same cycle.
REQ-035 SHALL write one entry per write-state cycle, with wr_en registered and asserted the cycle after the triggering event.
REQ-036 SHALL hold wr_addr and wr_data stable for the whole cycle in which wr_en is high.
REQ-037 SHALL ignore key_release in GAP and beat in IDLE.

Reset
REQ-038 SHALL, while reset==0 at a clk edge, go to IDLE and clear wr_en, wr_addr, wr_data, recording, full, entry_count, dur, index and all flags, including mid-write; no terminator is written.

Structure
REQ-039 SHALL take the state encoding, the entry-field positions (advance bit 15, note 11:6, duration 5:0) and SONG_ENTRIES=32 from the shared song package that song_reader also uses.
REQ-040 SHALL be a single module; the saturating beat counter may be split out as sub-module dur_counter.

Verification
REQ-041 SHALL be covered by: record, press note 20, 5 beats, release, record -> writes {1,20,5} at addr {song,0}, then terminator at 1; entry_count=2.
REQ-042 SHALL be covered by: note 10 held 3 beats, 4-beat gap, note 12 held 2 beats, stop -> writes {1,10,3}, {1,0,4}, {1,12,2}, terminator.
REQ-043 SHALL be covered by: note 7 held 70 beats -> writes {1,7,63} then {1,7,7} on release.
REQ-044 SHALL be covered by: 31 short notes -> 31 entries written, terminator at index 31, full=1, state IDLE, later keys ignored.
REQ-045 SHALL be covered by: beat coinciding with key_release at dur=4 -> entry duration 5.
REQ-046 SHALL be covered by: reset=0 during HOLD -> all outputs 0 next cycle, no wr_en, recording=0.

Source files
------------

// File: rtl/song_pkg.sv
// Shared song-memory definitions used by song_recorder and song_reader:
// recorder state encoding, entry field positions and the entry packer.
package song_pkg;

    localparam int SONG_ENTRIES = 32;
    localparam int ADV_BIT      = 15;
    localparam int NOTE_HI      = 11;
    localparam int NOTE_LO      = 6;
    localparam int DUR_HI       = 5;
    localparam int DUR_LO       = 0;

    // Last slot of a song; always holds the terminator once a take fills up.
    localparam logic [4:0] LAST_INDEX = 5'(SONG_ENTRIES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GAP     = 3'd1,
        HOLD    = 3'd2,
        WR_REST = 3'd3,
        WR_NOTE = 3'd4,
        WR_END  = 3'd5
    } rec_state_e;

    function automatic logic [15:0] make_entry(input logic       adv,
                                               input logic [5:0] note,
                                               input logic [5:0] dur);
        logic [15:0] e;
        e                  = 16'd0;
        e[ADV_BIT]         = adv;
        e[NOTE_HI:NOTE_LO] = note;
        e[DUR_HI:DUR_LO]   = dur;
        return e;
    endfunction

endpackage

// File: rtl/dur_counter.sv
// Saturating beat counter; o_dur_inc previews the count with this cycle's
// beat applied so the caller can act on it in the same cycle.
module dur_counter #(
    parameter int MAX_DUR = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_count,
    output logic [5:0] o_dur_inc
);

    localparam logic [5:0] MAX_V = 6'(MAX_DUR);

    logic [5:0] r_dur;

    // Next count: one more on a beat, held at the ceiling.
    always_comb begin
        o_dur_inc = r_dur;
        if (i_count && (r_dur < MAX_V)) begin
            o_dur_inc = r_dur + 6'd1;
        end else begin
            o_dur_inc = r_dur;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dur <= 6'd0;
        end else if (i_clr) begin
            r_dur <= 6'd0;
        end else begin
            r_dur <= o_dur_inc;
        end
    end

endmodule

// File: rtl/song_recorder.sv
// Records key presses into song memory as {advance, note, duration} entries,
// inserting rests between notes and closing each take with a terminator.
module song_recorder
    import song_pkg::*;
#(
    parameter int MAX_DUR = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        record_button,
    input  logic [1:0]  song,
    input  logic        beat,
    input  logic        key_press,
    input  logic [5:0]  key_note,
    input  logic        key_release,
    output logic        wr_en,
    output logic [6:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        recording,
    output logic        full,
    output logic [5:0]  entry_count
);

    localparam logic [5:0] MAX_V = 6'(MAX_DUR);

    rec_state_e  r_state;
    logic [1:0]  r_song;
    logic [4:0]  r_index;
    logic [5:0]  r_note;
    logic        r_first_key;
    logic        r_cont;
    logic        r_stop;
    logic        r_full;
    logic [5:0]  r_entry_count;
    logic        r_wr_en;
    logic [6:0]  r_wr_addr;
    logic [15:0] r_wr_data;
    logic        r_recording;

    rec_state_e  w_state_nxt;
    logic [1:0]  w_song_nxt;
    logic [4:0]  w_index_nxt;
    logic [5:0]  w_note_nxt;
    logic        w_first_key_nxt;
    logic        w_cont_nxt;
    logic        w_stop_nxt;
    logic        w_full_nxt;
    logic        w_cnt_clr;
    logic        w_dur_clr;
    logic        w_dur_cnt;
    logic [5:0]  w_dur_inc;
    logic        w_wr_en_nxt;
    logic [15:0] w_wr_data_nxt;

    dur_counter #(.MAX_DUR(MAX_DUR)) u_dur (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_dur_clr),
        .i_count   (w_dur_cnt),
        .o_dur_inc (w_dur_inc)
    );

    // Next-state and bookkeeping; record_button outranks key events, and
    // write states ignore every input.
    always_comb begin
        w_state_nxt     = r_state;
        w_song_nxt      = r_song;
        w_index_nxt     = r_index;
        w_note_nxt      = r_note;
        w_first_key_nxt = r_first_key;
        w_cont_nxt      = r_cont;
        w_stop_nxt      = r_stop;
        w_full_nxt      = r_full;
        w_cnt_clr       = 1'b0;
        w_dur_clr       = 1'b0;
        w_dur_cnt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (record_button) begin
                    w_song_nxt      = song;
                    w_index_nxt     = 5'd0;
                    w_first_key_nxt = 1'b0;
                    w_cont_nxt      = 1'b0;
                    w_stop_nxt      = 1'b0;
                    w_full_nxt      = 1'b0;
                    w_cnt_clr       = 1'b1;
                    w_dur_clr       = 1'b1;
                    w_state_nxt     = GAP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GAP: begin
                w_dur_cnt = beat;
                if (record_button) begin
                    w_state_nxt = WR_END;
                end else if (key_press) begin
                    w_note_nxt = key_note;
                    if (r_first_key && (w_dur_inc != 6'd0)) begin
                        w_state_nxt = WR_REST;
                    end else begin
                        // Silence before the first key is never recorded.
                        w_dur_clr       = 1'b1;
                        w_first_key_nxt = 1'b1;
                        w_state_nxt     = HOLD;
                    end
                end else begin
                    w_state_nxt = GAP;
                end
            end
            HOLD: begin
                w_dur_cnt = beat;
                if (record_button) begin
                    if (w_dur_inc != 6'd0) begin
                        w_stop_nxt  = 1'b1;
                        w_cont_nxt  = 1'b0;
                        w_state_nxt = WR_NOTE;
                    end else begin
                        w_state_nxt = WR_END;
                    end
                end else if (key_release) begin
                    w_cont_nxt  = 1'b0;
                    w_state_nxt = WR_NOTE;
                end else if (w_dur_inc == MAX_V) begin
                    w_cont_nxt  = 1'b1;
                    w_state_nxt = WR_NOTE;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            WR_REST: begin
                w_index_nxt = r_index + 5'd1;
                w_dur_clr   = 1'b1;
                if (w_index_nxt == LAST_INDEX) begin
                    w_full_nxt  = 1'b1;
                    w_state_nxt = WR_END;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            WR_NOTE: begin
                w_index_nxt = r_index + 5'd1;
                w_dur_clr   = 1'b1;
                w_cont_nxt  = 1'b0;
                if (w_index_nxt == LAST_INDEX) begin
                    w_full_nxt  = 1'b1;
                    w_state_nxt = WR_END;
                end else if (r_stop) begin
                    w_state_nxt = WR_END;
                end else if (r_cont) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = GAP;
                end
            end
            WR_END: begin
                w_stop_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Entry word for the write state being entered; dur already holds this beat.
    always_comb begin
        w_wr_en_nxt   = 1'b0;
        w_wr_data_nxt = 16'd0;
        case (w_state_nxt)
            WR_REST: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = make_entry(1'b1, 6'd0, w_dur_inc);
            end
            WR_NOTE: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = make_entry(1'b1, w_note_nxt, w_dur_inc);
            end
            WR_END: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = make_entry(1'b0, 6'd0, 6'd0);
            end
            default: begin
                w_wr_en_nxt   = 1'b0;
                w_wr_data_nxt = 16'd0;
            end
        endcase
    end

    // State, take bookkeeping and registered memory-write outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_song        <= 2'd0;
            r_index       <= 5'd0;
            r_note        <= 6'd0;
            r_first_key   <= 1'b0;
            r_cont        <= 1'b0;
            r_stop        <= 1'b0;
            r_full        <= 1'b0;
            r_entry_count <= 6'd0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= 7'd0;
            r_wr_data     <= 16'd0;
            r_recording   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_song        <= w_song_nxt;
            r_index       <= w_index_nxt;
            r_note        <= w_note_nxt;
            r_first_key   <= w_first_key_nxt;
            r_cont        <= w_cont_nxt;
            r_stop        <= w_stop_nxt;
            r_full        <= w_full_nxt;
            r_entry_count <= w_cnt_clr ? 6'd0 : (r_entry_count + {5'd0, w_wr_en_nxt});
            r_wr_en       <= w_wr_en_nxt;
            r_wr_addr     <= w_wr_en_nxt ? {w_song_nxt, w_index_nxt} : 7'd0;
            r_wr_data     <= w_wr_data_nxt;
            r_recording   <= (w_state_nxt != IDLE);
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign recording   = r_recording;
    assign full        = r_full;
    assign entry_count = r_entry_count;

endmodule

// File: tb/tb_song_recorder.sv
// Bench for song_recorder: cycle table, directed takes and random takes
// scored against an entry-list model built from the recording rules.
module tb_song_recorder;

    logic        clk = 1'b0;
    logic        reset, record_button, beat, key_press, key_release;
    logic [1:0]  song;
    logic [5:0]  key_note;
    logic        wr_en, recording, full;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic [5:0]  entry_count;

    int total = 0;
    int bad   = 0;

    logic [22:0] got_q[$];
    logic [22:0] exp_q[$];

    typedef struct {
        logic rb; logic kp; logic [5:0] kn; logic kr; logic bt;
        logic e_wr; logic [6:0] e_addr; logic [15:0] e_data; logic e_rec; logic [5:0] e_cnt;
    } vec_t;
    vec_t tv[16];

    // Take description shared by the driver and the model.
    logic [1:0] t_song;
    int  t_n, t_tail;
    bit  t_rel_last;
    int  t_note[8], t_hold[8], t_gap[8];

    song_recorder #(.MAX_DUR(63)) dut (
        .clk(clk), .reset(reset), .record_button(record_button), .song(song),
        .beat(beat), .key_press(key_press), .key_note(key_note), .key_release(key_release),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .recording(recording),
        .full(full), .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) got_q.push_back({wr_addr, wr_data});
    end

    function automatic logic [15:0] entry(input logic adv, input logic [5:0] n, input logic [5:0] d);
        return {adv, 3'b000, n, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rb, input logic kp, input logic [5:0] kn, input logic kr, input logic bt);
        record_button = rb; key_press = kp; key_note = kn; key_release = kr; beat = bt;
        @(posedge clk); #1;
        record_button = 1'b0; key_press = 1'b0; key_note = 6'd0; key_release = 1'b0; beat = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic ev_record();            cyc(1'b1, 1'b0, 6'd0, 1'b0, 1'b0); idle(1); endtask
    task automatic ev_press(input int n);  cyc(1'b0, 1'b1, 6'(n), 1'b0, 1'b0); idle(1); endtask
    task automatic ev_release();           cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b0); idle(1); endtask
    task automatic ev_beat();              cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b1); idle(1); endtask

    task automatic drive_take();
        song = t_song;
        ev_record();
        for (int k = 0; k < t_n; k++) begin
            repeat (t_gap[k]) ev_beat();
            ev_press(t_note[k]);
            repeat (t_hold[k]) ev_beat();
            if (k != t_n - 1 || t_rel_last) ev_release();
        end
        repeat (t_tail) ev_beat();
        ev_record();
        idle(4);
    endtask

    // Expected entry list: rests only between notes, long notes split into
    // 63-beat pieces, an unreleased last note flushed only if time remains.
    function automatic void model_build();
        int idx = 0;
        int h;
        exp_q.delete();
        for (int k = 0; k < t_n; k++) begin
            if (k > 0 && t_gap[k] > 0) begin
                exp_q.push_back({t_song, 5'(idx), entry(1'b1, 6'd0, 6'((t_gap[k] > 63) ? 63 : t_gap[k]))});
                idx++;
            end
            h = t_hold[k];
            while (h >= 63) begin
                exp_q.push_back({t_song, 5'(idx), entry(1'b1, 6'(t_note[k]), 6'd63)});
                idx++;
                h -= 63;
            end
            if (k != t_n - 1 || t_rel_last || h > 0) begin
                exp_q.push_back({t_song, 5'(idx), entry(1'b1, 6'(t_note[k]), 6'(h))});
                idx++;
            end
        end
        exp_q.push_back({t_song, 5'(idx), 16'd0});
    endfunction

    task automatic cmp_take(input string nm);
        check({nm, "_n"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_e%0d", nm, i), got_q[i], exp_q[i]);
        check({nm, "_entry_count"}, entry_count, exp_q.size());
        check({nm, "_recording"}, recording, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic setv(input int i, input logic rb, input logic kp, input logic [5:0] kn,
                        input logic kr, input logic bt, input logic e_wr, input logic [6:0] e_addr,
                        input logic [15:0] e_data, input logic e_rec, input logic [5:0] e_cnt);
        tv[i] = '{rb, kp, kn, kr, bt, e_wr, e_addr, e_data, e_rec, e_cnt};
    endtask

    initial begin
        reset = 1'b0; record_button = 1'b0; beat = 1'b0; key_press = 1'b0;
        key_release = 1'b0; key_note = 6'd0; song = 2'd0;
        t_n = 0; t_tail = 0; t_rel_last = 1'b1; t_song = 2'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_rec", recording, 0);
        check("rst_full", full, 0);
        check("rst_cnt", entry_count, 0);
        reset = 1'b1;
        idle(1);

        // Cycle table: song 2, note 20 held 5 beats, then stop.
        song = 2'd2;
        setv(0,  1,0,6'd0, 0,0, 0,7'h00,16'h0000, 1,6'd0);
        setv(1,  0,1,6'd20,0,0, 0,7'h00,16'h0000, 1,6'd0);
        for (int i = 2; i <= 11; i++)
            setv(i, 0,0,6'd0,0,((i % 2) == 0) ? 1'b1 : 1'b0, 0,7'h00,16'h0000, 1,6'd0);
        setv(12, 0,0,6'd0, 1,0, 1,7'h40,16'h8505, 1,6'd1);
        setv(13, 0,0,6'd0, 0,0, 0,7'h00,16'h0000, 1,6'd1);
        setv(14, 1,0,6'd0, 0,0, 1,7'h41,16'h0000, 1,6'd2);
        setv(15, 0,0,6'd0, 0,0, 0,7'h00,16'h0000, 0,6'd2);
        for (int i = 0; i < 16; i++) begin
            cyc(tv[i].rb, tv[i].kp, tv[i].kn, tv[i].kr, tv[i].bt);
            check($sformatf("vec%0d_wr_en", i), wr_en, tv[i].e_wr);
            if (tv[i].e_wr) begin
                check($sformatf("vec%0d_addr", i), wr_addr, tv[i].e_addr);
                check($sformatf("vec%0d_data", i), wr_data, tv[i].e_data);
            end
            check($sformatf("vec%0d_rec", i), recording, tv[i].e_rec);
            check($sformatf("vec%0d_cnt", i), entry_count, tv[i].e_cnt);
        end
        idle(2);
        got_q.delete();

        // Two notes with a rest between them.
        t_song = 2'd3; t_n = 2; t_rel_last = 1'b1; t_tail = 0;
        t_note[0] = 10; t_hold[0] = 3; t_gap[0] = 0;
        t_note[1] = 12; t_hold[1] = 2; t_gap[1] = 4;
        drive_take();
        exp_q.push_back({2'd3, 5'd0, entry(1'b1, 6'd10, 6'd3)});
        exp_q.push_back({2'd3, 5'd1, entry(1'b1, 6'd0,  6'd4)});
        exp_q.push_back({2'd3, 5'd2, entry(1'b1, 6'd12, 6'd2)});
        exp_q.push_back({2'd3, 5'd3, 16'd0});
        cmp_take("two_notes");

        // Note longer than one entry can hold.
        t_song = 2'd0; t_n = 1; t_note[0] = 7; t_hold[0] = 70; t_gap[0] = 0;
        drive_take();
        exp_q.push_back({2'd0, 5'd0, entry(1'b1, 6'd7, 6'd63)});
        exp_q.push_back({2'd0, 5'd1, entry(1'b1, 6'd7, 6'd7)});
        exp_q.push_back({2'd0, 5'd2, 16'd0});
        cmp_take("long_note");

        // Leading silence dropped and trailing rest discarded.
        t_song = 2'd2; t_n = 1; t_note[0] = 5; t_hold[0] = 2; t_gap[0] = 6; t_tail = 3;
        drive_take();
        exp_q.push_back({2'd2, 5'd0, entry(1'b1, 6'd5, 6'd2)});
        exp_q.push_back({2'd2, 5'd1, 16'd0});
        cmp_take("silences");
        t_tail = 0;

        // Beat coinciding with release counts toward the note.
        song = 2'd1;
        ev_record(); ev_press(9);
        repeat (4) ev_beat();
        cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b1); idle(1);
        ev_record(); idle(4);
        exp_q.push_back({2'd1, 5'd0, entry(1'b1, 6'd9, 6'd5)});
        exp_q.push_back({2'd1, 5'd1, 16'd0});
        cmp_take("beat_release");

        // Fill the song: 31 notes, terminator forced into slot 31.
        song = 2'd1;
        ev_record();
        for (int k = 0; k < 31; k++) begin
            ev_press(k + 1); ev_beat(); ev_release();
            exp_q.push_back({2'd1, 5'(k), entry(1'b1, 6'(k + 1), 6'd1)});
        end
        exp_q.push_back({2'd1, 5'd31, 16'd0});
        idle(4);
        check("full_flag", full, 1);
        cmp_take("full");
        ev_press(3); ev_beat(); ev_release(); idle(2);
        check("full_keys_ignored", got_q.size(), 0);
        check("full_rec_after", recording, 0);
        check("full_flag_held", full, 1);

        // Reset while holding a note.
        song = 2'd2;
        ev_record(); ev_press(4); ev_beat(); ev_beat();
        got_q.delete();
        reset = 1'b0;
        @(posedge clk); #1;
        check("hreset_wr_en", wr_en, 0);
        check("hreset_addr", wr_addr, 0);
        check("hreset_data", wr_data, 0);
        check("hreset_rec", recording, 0);
        check("hreset_full", full, 0);
        check("hreset_cnt", entry_count, 0);
        reset = 1'b1;
        ev_release(); ev_beat(); idle(3);
        check("hreset_no_write", got_q.size(), 0);
        check("hreset_rec_after", recording, 0);

        // Random takes against the model.
        for (int t = 0; t < 12; t++) begin
            t_song = 2'($urandom_range(0, 3));
            t_n = $urandom_range(1, 6);
            for (int k = 0; k < t_n; k++) begin
                t_note[k] = $urandom_range(1, 63);
                t_hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(55, 130) : $urandom_range(0, 10);
                t_gap[k]  = ($urandom_range(0, 4) == 0) ? $urandom_range(55, 75) : $urandom_range(0, 8);
            end
            t_rel_last = ($urandom_range(0, 1) == 1);
            t_tail = t_rel_last ? $urandom_range(0, 5) : 0;
            model_build();
            drive_take();
            cmp_take($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
